spi_burst_ctrl: RTL



---
 rtl/spi_burst_ctrl_if.sv | 34 +++
 rtl/spi_burst_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ctrl_if.sv
// Signal bundle between spi_burst_ctrl, its host, and the downstream spi_master.
// The slave modport is the controller's view; the master modport is the host/master side.
interface spi_burst_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 5
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [LEN_W-1:0]      tx_level;
    logic                  burst_start;
    logic [LEN_W-1:0]      burst_len;
    logic                  busy;
    logic                  burst_done;
    logic                  burst_err;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] m_data_send;
    logic                  m_spi_start;
    logic                  m_spi_done;
    logic [DATA_WIDTH-1:0] m_data_recv;

    modport slave (
        input  tx_data, tx_valid, burst_start, burst_len, m_spi_done, m_data_recv,
        output tx_ready, tx_level, busy, burst_done, burst_err, rx_data, rx_valid,
               m_data_send, m_spi_start
    );

    modport master (
        output tx_data, tx_valid, burst_start, burst_len, m_spi_done, m_data_recv,
        input  tx_ready, tx_level, busy, burst_done, burst_err, rx_data, rx_valid,
               m_data_send, m_spi_start
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of spi_master: buffers TX words in a FIFO and issues them
// one per SPI transfer, separated by GAP_CYCLES idle cycles, returning each received word.
module spi_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2,
    parameter int LEN_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_burst_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LEN_W-1:0]      level_r;
    logic [LEN_W-1:0]      level_nxt_s;
    logic [LEN_W-1:0]      remaining_r;
    logic [GAP_W-1:0]      gap_cnt_r;
    logic                  tx_ready_r;
    logic                  busy_r;
    logic                  burst_done_r;
    logic                  burst_err_r;
    logic                  rx_valid_r;
    logic                  m_spi_start_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic [DATA_WIDTH-1:0] m_data_send_r;
    logic                  push_s;
    logic                  pop_s;

    // Push/pop qualification and next FIFO occupancy.
    always_comb begin
        push_s = bus.tx_valid && tx_ready_r;
        pop_s  = (state_r == ST_ISSUE);
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LEN_W'(1'b1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LEN_W'(1'b1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // FIFO storage; contents need no reset because the pointers and level do.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.tx_data;
        end
    end

    // FIFO pointers, occupancy and registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            tx_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            level_r    <= level_nxt_s;
            tx_ready_r <= (level_nxt_s != LEN_W'(DEPTH));
        end
    end

    // Burst sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            remaining_r   <= '0;
            gap_cnt_r     <= '0;
            busy_r        <= 1'b0;
            burst_done_r  <= 1'b0;
            burst_err_r   <= 1'b0;
            rx_valid_r    <= 1'b0;
            rx_data_r     <= '0;
            m_spi_start_r <= 1'b0;
            m_data_send_r <= '0;
        end else begin
            m_spi_start_r <= 1'b0;
            rx_valid_r    <= 1'b0;
            burst_done_r  <= 1'b0;
            burst_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A zero-length request is a no-op, not an error.
                    if (bus.burst_start && (bus.burst_len != '0)) begin
                        if (bus.burst_len > level_r) begin
                            burst_err_r <= 1'b1;
                        end else begin
                            remaining_r <= bus.burst_len;
                            busy_r      <= 1'b1;
                            state_r     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    m_data_send_r <= mem_r[rd_ptr_r];
                    m_spi_start_r <= 1'b1;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.m_spi_done) begin
                        rx_data_r   <= bus.m_data_recv;
                        rx_valid_r  <= 1'b1;
                        remaining_r <= remaining_r - LEN_W'(1'b1);
                        if (remaining_r == LEN_W'(1'b1)) begin
                            burst_done_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            gap_cnt_r <= '0;
                            state_r   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready    = tx_ready_r;
    assign bus.tx_level    = level_r;
    assign bus.busy        = busy_r;
    assign bus.burst_done  = burst_done_r;
    assign bus.burst_err   = burst_err_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.m_data_send = m_data_send_r;
    assign bus.m_spi_start = m_spi_start_r;
endmodule
